// File: rtl/unit_dispatch_pkg.sv
// unit_dispatch_pkg: dispatcher FSM states and named unit indices
package unit_dispatch_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} dispatch_state_t;
  localparam int UNIT_IDX_ALU = 0;
  localparam int UNIT_IDX_MEM = 1;
endpackage

// File: rtl/dispatch_timer.sv
// dispatch_timer: issue timeout counter with clear/enable, expired on the last allowed cycle
module dispatch_timer #(
  parameter int CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(CYCLES + 1);
  logic [CW-1:0] cnt;
  // count ISSUE cycles spent waiting for the selected unit
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= cnt + CW'(1);
  assign expired = cnt == CW'(CYCLES - 1);
endmodule

// File: rtl/unit_dispatch.sv
// unit_dispatch: single-outstanding N-way unit dispatcher; UNIT_DISPATCH_TIMEOUT_EN adds an issue timeout
module unit_dispatch
  import unit_dispatch_pkg::*;
#(
  parameter int N_UNITS        = 4,
  parameter int WORD_W         = 32,
  parameter int N_OPS          = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [$clog2(N_UNITS+1)-1:0] req_sel,
  input  logic [N_OPS*WORD_W-1:0]     req_data,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [WORD_W-1:0]           rsp_data,
  output logic                        rsp_err,
  output logic [N_UNITS-1:0]          unit_valid,
  output logic [N_OPS*WORD_W-1:0]     unit_data,
  input  logic [N_UNITS-1:0]          unit_ready,
  input  logic [N_UNITS*WORD_W-1:0]   unit_rdata,
  output logic                        busy
);
  localparam int SW = $clog2(N_UNITS + 1);
  dispatch_state_t state, state_n;
  logic [SW-1:0] sel_q;
  logic [N_OPS*WORD_W-1:0] data_q;
  logic [WORD_W-1:0] rsp_data_q, rdata_sel;
  logic [N_UNITS-1:0] onehot;
  logic rsp_err_q, ready_sel, timed_out, accept, sel_ok, issuing;
  assign sel_ok  = req_sel < SW'(N_UNITS);
  assign accept  = req_valid && req_ready;
  assign issuing = state == ISSUE;
  // decode the latched select into strobe, ready and result lanes
  always_comb begin
    onehot    = '0;
    ready_sel = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < N_UNITS; i++)
      if (sel_q == SW'(i)) begin
        onehot[i] = 1'b1;
        ready_sel = unit_ready[i];
        rdata_sel = unit_rdata[i*WORD_W +: WORD_W];
      end
  end
`ifdef UNIT_DISPATCH_TIMEOUT_EN
  logic expired;
  dispatch_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept && sel_ok),
    .en     (issuing && !ready_sel),
    .expired(expired)
  );
  assign timed_out = issuing && expired && !ready_sel;
`else
  assign timed_out = 1'b0;
`endif
  // next-state logic
  always_comb
    state_n = state == IDLE  ? (accept ? (sel_ok ? ISSUE : RESP) : IDLE) :
              state == ISSUE ? ((ready_sel || timed_out) ? RESP : ISSUE) :
                               (rsp_ready ? IDLE : RESP);
  // state register plus request and response latches
  always_ff @(posedge clk)
    if (rst) begin
      state      <= IDLE;
      sel_q      <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        sel_q      <= req_sel;
        data_q     <= req_data;
        rsp_data_q <= '0;
        rsp_err_q  <= !sel_ok;
      end else if (issuing && ready_sel) begin
        rsp_data_q <= rdata_sel;
        rsp_err_q  <= 1'b0;
      end else if (timed_out) begin
        rsp_data_q <= '0;
        rsp_err_q  <= 1'b1;
      end
    end
  assign req_ready  = !rst && state == IDLE;
  assign rsp_valid  = !rst && state == RESP;
  assign busy       = !rst && state != IDLE;
  assign unit_valid = (!rst && issuing) ? onehot : '0;
  assign unit_data  = (!rst && issuing) ? data_q : '0;
  assign rsp_data   = rst ? '0 : rsp_data_q;
  assign rsp_err    = !rst && rsp_err_q;
endmodule

// File: tb/tb_unit_dispatch.sv
// tb_unit_dispatch: directed self-checking bench for unit_dispatch
module tb_unit_dispatch;
  logic clk = 0, rst = 1, req_valid = 0, rsp_ready = 0;
  logic req_ready, rsp_valid, rsp_err, busy;
  logic [2:0] req_sel = '0;
  logic [95:0] req_data = '0, unit_data;
  logic [31:0] rsp_data;
  logic [3:0] unit_valid, unit_ready = '0;
  logic [127:0] unit_rdata;
  int n_chk = 0, n_pass = 0;

  unit_dispatch #(.N_UNITS(4), .WORD_W(32), .N_OPS(3), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_data(req_data), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .unit_valid(unit_valid), .unit_data(unit_data), .unit_ready(unit_ready),
    .unit_rdata(unit_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  assign unit_rdata = {32'hCAFE_0003, 32'hD00D_0002, 32'hBEEF_0001, 32'h0000_1234};

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_unit_valid"}, unit_valid, 0);
  endtask

  task automatic reset_chk(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_unit_valid"}, unit_valid, 0);
    check({tag, "_unit_data"}, unit_data, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
  endtask

  task automatic send(input logic [2:0] sel, input logic [95:0] data);
    req_valid = 1;
    req_sel   = sel;
    req_data  = data;
    step();
    req_valid = 0;
  endtask

  initial begin
    step();
    step();
    reset_chk("rst");
    rst = 0;
    step();
    idle_chk("post_rst");

    // unit 0 ready immediately: 2-cycle latency
    unit_ready = 4'b0001;
    send(3'd0, 96'h1111_2222_3333_4444_5555_6666);
    check("t1_uv", unit_valid, 4'b0001);
    check("t1_ud", unit_data, 96'h1111_2222_3333_4444_5555_6666);
    check("t1_rr", req_ready, 0);
    check("t1_rv0", rsp_valid, 0);
    step();
    check("t1_rv", rsp_valid, 1);
    check("t1_rd", rsp_data, 32'h0000_1234);
    check("t1_err", rsp_err, 0);
    check("t1_uv_off", unit_valid, 0);
    check("t1_ud_off", unit_data, 0);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    idle_chk("t1_done");

    // unit 1 ready after 3 issue cycles, others ready but ignored, extra req_valid while busy
    unit_ready = 4'b1101;
    send(3'd1, 96'hA);
    req_valid = 1;
    req_sel   = 3'd2;
    for (int i = 0; i < 3; i++) begin
      check("t2_uv", unit_valid, 4'b0010);
      check("t2_rr", req_ready, 0);
      check("t2_rv0", rsp_valid, 0);
      if (i == 2) unit_ready = 4'b0010;
      step();
    end
    unit_ready = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      check("t2_rv", rsp_valid, 1);
      check("t2_rd", rsp_data, 32'hBEEF_0001);
      check("t2_err", rsp_err, 0);
      check("t2_rr_stall", req_ready, 0);
      if (i == 2) rsp_ready = 1;
      step();
    end
    req_valid = 0;
    rsp_ready = 0;
    idle_chk("t2_done");
    step();
    idle_chk("t2_no_extra");

    // bad selects touch no unit
    for (int s = 4; s <= 5; s++) begin
      send(3'(s), 96'hF);
      check("t3_rv", rsp_valid, 1);
      check("t3_err", rsp_err, 1);
      check("t3_rd", rsp_data, 0);
      check("t3_uv", unit_valid, 0);
      check("t3_busy", busy, 1);
      rsp_ready = 1;
      step();
      rsp_ready = 0;
      check("t3_uv_after", unit_valid, 0);
      idle_chk("t3_done");
    end

    // reset in the second ISSUE cycle, then a late ready
    send(3'd2, 96'h22);
    step();
    check("t4_uv", unit_valid, 4'b0100);
    rst = 1;
    #1;
    reset_chk("t4_rst");
    unit_ready = 4'b0100;
    step();
    rst = 0;
    step();
    idle_chk("t4_after");
    send(3'd2, 96'h33);
    check("t4_uv2", unit_valid, 4'b0100);
    check("t4_ud2", unit_data, 96'h33);
    step();
    check("t4_rv", rsp_valid, 1);
    check("t4_rd", rsp_data, 32'hD00D_0002);
    check("t4_err", rsp_err, 0);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    unit_ready = 0;
    idle_chk("t4_done");

`ifdef UNIT_DISPATCH_TIMEOUT_EN
    // never ready: exactly 4 issue cycles then error; then ready in the 4th cycle wins
    for (int r = 0; r < 2; r++) begin
      unit_ready = 0;
      send(3'd3, 96'h44);
      for (int i = 0; i < 4; i++) begin
        check("t5_uv", unit_valid, 4'b1000);
        if (r == 1 && i == 3) unit_ready = 4'b1000;
        step();
      end
      check("t5_rv", rsp_valid, 1);
      check("t5_err", rsp_err, r == 0);
      check("t5_rd", rsp_data, r == 0 ? 32'h0 : 32'hCAFE_0003);
      check("t5_uv_off", unit_valid, 0);
      rsp_ready = 1;
      step();
      rsp_ready = 0;
      idle_chk("t5_done");
    end
`else
    // no timeout: ISSUE waits indefinitely
    unit_ready = 0;
    send(3'd3, 96'h44);
    for (int i = 0; i < 10; i++) begin
      check("t5_uv", unit_valid, 4'b1000);
      check("t5_rv0", rsp_valid, 0);
      step();
    end
    check("t5_uv_wait", unit_valid, 4'b1000);
    unit_ready = 4'b1000;
    step();
    check("t5_rv", rsp_valid, 1);
    check("t5_err", rsp_err, 0);
    check("t5_rd", rsp_data, 32'hCAFE_0003);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    idle_chk("t5_done");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/unit_dispatch.md
# unit_dispatch

Parametrised request dispatcher between a hart thread and N execution units (ALU, memory port, future CSR/MUL units). Latches one request, drives the selected unit through a valid/ready handshake, captures its result and returns it to the thread through a response handshake. Supersedes fixed NONE/ALU/MEM muxing with an N-way, single-outstanding, optionally timed-out dispatcher.

## Interface
Parameters:
- N_UNITS, 4, number of attached units; `req_sel` values 0..N_UNITS-1 are valid.
- WORD_W, 32, word width.
- N_OPS, 3, operand words per request (word 0 = unit control, 1..N_OPS-1 = operands).
- TIMEOUT_CYCLES, 255, maximum cycles `unit_valid` stays high without `unit_ready`; must be ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- req_valid  in  1  thread request present.
- req_ready  out  1  dispatcher can accept.
- req_sel  in  $clog2(N_UNITS+1)  target unit index.
- req_data  in  N_OPS*WORD_W  request operands.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  thread accepts response.
- rsp_data  out  WORD_W  result word.
- rsp_err  out  1  bad select or timeout.
- unit_valid  out  N_UNITS  one-hot issue strobe.
- unit_data  out  N_OPS*WORD_W  latched operands, broadcast to all units.
- unit_ready  in  N_UNITS  per-unit completion.
- unit_rdata  in  N_UNITS*WORD_W  per-unit result, slice i = unit i.
- busy  out  1  high in any state other than IDLE.

One clock; reset is synchronous and active-high.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, latch `req_sel` and `req_data`. If `req_sel` < N_UNITS, go to ISSUE. Otherwise go to RESP with `rsp_err`=1 and `rsp_data`=0; no unit is touched.
- ISSUE: `unit_valid[sel]`=1, all other bits 0. `unit_data` = latched operands. On `unit_ready[sel]`, capture slice `sel` of `unit_rdata` into `rsp_data`, set `rsp_err`=0, and go to RESP. `unit_ready` of unselected units is ignored.
- RESP: `rsp_valid`=1; `rsp_data` and `rsp_err` are held stable. On `rsp_ready`, go to IDLE.
- Only one request is outstanding. `req_valid` outside IDLE is not accepted.
- `unit_data` is 0 outside ISSUE.
- Reset values (and values while `rst` is high): state IDLE, `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `unit_valid`=0, `unit_data`=0, `busy`=0, timeout counter 0.
- Reset asserted mid-ISSUE or mid-RESP aborts the operation. The pending response is discarded and no late `unit_ready` is honoured.

## Timing
- Accept on edge k. `unit_valid` is high in cycle k+1. If `unit_ready` is high in that cycle, `rsp_valid` is high in cycle k+2. Minimum accept-to-response latency is 2 cycles.
- With `rsp_ready` tied high, back-to-back throughput is one request per 3 cycles (IDLE, ISSUE, RESP).
- Bad select: `rsp_valid` in cycle k+1 with `rsp_err`=1.
- `req_ready` is a combinational function of state and `rst` only. It does not depend on `req_valid`.

## Configuration
- `UNIT_DISPATCH_TIMEOUT_EN` defined:
  - Counter clears on entry to ISSUE and increments each ISSUE cycle without `unit_ready[sel]`.
  - If the counter equals TIMEOUT_CYCLES-1 and ready is still low, go to RESP with `rsp_err`=1 and `rsp_data`=0. `unit_valid` is therefore high for exactly TIMEOUT_CYCLES cycles.
  - Ready arriving in the final cycle wins: the request succeeds.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Not defined: no counter; ISSUE waits indefinitely. `rsp_err` is raised only for a bad select.

## Structure
- `types.sv` (shared) gains the `dispatch_state_t` enum (IDLE, ISSUE, RESP) and named unit-index constants (UNIT_IDX_ALU=0, UNIT_IDX_MEM=1).
- One sub-module, `dispatch_timer`, holds the timeout counter with clear/enable inputs and an `expired` output. It is instantiated only under `UNIT_DISPATCH_TIMEOUT_EN`.

## Test plan
- ALU-style unit 0 with `unit_ready` tied 1, `unit_rdata[0]`=0x0000_1234. Accept a request at cycle 0 → `unit_valid`=4'b0001 at cycle 1, `rsp_valid` with `rsp_data`=0x1234 and `rsp_err`=0 at cycle 2.
- Unit 1 raises ready 3 cycles after issue, `rsp_ready` held low for 2 cycles. Expect `unit_valid[1]` high for 3 cycles, `rsp_data` stable through the stall, and `req_ready`=0 throughout.
- `req_sel`=5 with N_UNITS=4 → `rsp_err`=1 and `rsp_data`=0 at cycle 1; `unit_valid` never leaves 0.
- Macro on, TIMEOUT_CYCLES=4, unit never ready → `unit_valid` high for exactly 4 cycles, then `rsp_err`=1. Repeat with ready in the 4th cycle → success.
- `rst` pulsed in the second ISSUE cycle, then unit ready asserted → outputs at reset values, no `rsp_valid`; a subsequent request completes normally.
- Extra `req_valid` pulses while busy → ignored; exactly one response per accepted request.
